// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, debounces lock, then releases the system reset.
// Optional define PLL_SEQ_STATUS_EN adds the lock_loss_cnt status output.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 64,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES         = 4,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                               refclk,
  input  logic                               rst_n,
  input  logic                               pll_locked,
  input  logic                               sw_relock,
  output logic                               pll_rst,
  output logic                               sys_reset_n,
  output logic                               pll_ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [2:0]                         state
`ifdef PLL_SEQ_STATUS_EN
  ,
  output logic [7:0]                         lock_loss_cnt
`endif
);

  localparam int RCW = $clog2(RST_PULSE_CYCLES) + 1;
  localparam int SCW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int TCW = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam int RW  = $clog2(MAX_RETRIES + 1);

  localparam logic [RCW-1:0] RST_LAST   = RCW'(RST_PULSE_CYCLES - 1);
  localparam logic [RCW-1:0] RST_ONE    = RCW'(1);
  localparam logic [SCW-1:0] STAB_LAST  = SCW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [SCW-1:0] STAB_ONE   = SCW'(1);
  localparam logic [TCW-1:0] TMO_LAST   = TCW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_ONE    = TCW'(1);
  localparam logic [RW-1:0]  RETRY_LAST = RW'(MAX_RETRIES - 1);
  localparam logic [RW-1:0]  RETRY_MAX  = RW'(MAX_RETRIES);
  localparam logic [RW-1:0]  RETRY_ONE  = RW'(1);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  state_e                 state_r, state_nxt_s, fail_state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   lk_s;
  logic [RCW-1:0]         rst_cnt_r, rst_cnt_nxt_s;
  logic [SCW-1:0]         stab_cnt_r, stab_cnt_nxt_s;
  logic [TCW-1:0]         tmo_cnt_r, tmo_cnt_nxt_s;
  logic [RW-1:0]          retry_r, retry_nxt_s, fail_retry_s;
  logic                   pll_rst_r, sys_reset_n_r, pll_ready_r, fault_r;

  assign lk_s = sync_r[SYNC_STAGES-1];

  // Lock synchronizer chain on the asynchronous pll_locked input.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Next-state, counter and retry decode; sw_relock overrides everything.
  always_comb begin
    state_nxt_s    = state_r;
    rst_cnt_nxt_s  = '0;
    stab_cnt_nxt_s = stab_cnt_r;
    tmo_cnt_nxt_s  = tmo_cnt_r;
    retry_nxt_s    = retry_r;
    if (retry_r >= RETRY_LAST) begin
      fail_state_s = ST_FAULT;
      fail_retry_s = RETRY_MAX;
    end else begin
      fail_state_s = ST_RESET;
      fail_retry_s = retry_r + RETRY_ONE;
    end
    if (sw_relock) begin
      state_nxt_s    = ST_RESET;
      stab_cnt_nxt_s = '0;
      tmo_cnt_nxt_s  = '0;
      retry_nxt_s    = '0;
    end else begin
      case (state_r)
        ST_RESET: begin
          tmo_cnt_nxt_s  = '0;
          stab_cnt_nxt_s = '0;
          if (rst_cnt_r >= RST_LAST) begin
            state_nxt_s = ST_WAIT_LOCK;
          end else begin
            rst_cnt_nxt_s = rst_cnt_r + RST_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (tmo_cnt_r == TMO_LAST) begin
            state_nxt_s = fail_state_s;
            retry_nxt_s = fail_retry_s;
          end else begin
            tmo_cnt_nxt_s = (tmo_cnt_r == '1) ? tmo_cnt_r : tmo_cnt_r + TMO_ONE;
            if (lk_s) begin
              state_nxt_s    = ST_STABLE;
              stab_cnt_nxt_s = '0;
            end else begin
              state_nxt_s = ST_WAIT_LOCK;
            end
          end
        end
        ST_STABLE: begin
          // Debounce completion outranks a timeout landing on the same cycle.
          if (lk_s && (stab_cnt_r == STAB_LAST)) begin
            state_nxt_s = ST_RUN;
            retry_nxt_s = '0;
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_nxt_s = fail_state_s;
            retry_nxt_s = fail_retry_s;
          end else begin
            tmo_cnt_nxt_s = (tmo_cnt_r == '1) ? tmo_cnt_r : tmo_cnt_r + TMO_ONE;
            if (lk_s) begin
              stab_cnt_nxt_s = (stab_cnt_r == '1) ? stab_cnt_r : stab_cnt_r + STAB_ONE;
            end else begin
              state_nxt_s = ST_WAIT_LOCK;
            end
          end
        end
        ST_RUN: begin
          if (!lk_s) begin
            state_nxt_s = ST_RESET;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_FAULT: begin
          state_nxt_s = ST_FAULT;
        end
        default: begin
          state_nxt_s = ST_RESET;
          retry_nxt_s = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RESET;
      rst_cnt_r     <= '0;
      stab_cnt_r    <= '0;
      tmo_cnt_r     <= '0;
      retry_r       <= '0;
      pll_rst_r     <= 1'b1;
      sys_reset_n_r <= 1'b0;
      pll_ready_r   <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      rst_cnt_r     <= rst_cnt_nxt_s;
      stab_cnt_r    <= stab_cnt_nxt_s;
      tmo_cnt_r     <= tmo_cnt_nxt_s;
      retry_r       <= retry_nxt_s;
      pll_rst_r     <= (state_nxt_s == ST_RESET) || (state_nxt_s == ST_FAULT);
      sys_reset_n_r <= (state_nxt_s == ST_RUN);
      pll_ready_r   <= (state_nxt_s == ST_RUN);
      fault_r       <= (state_nxt_s == ST_FAULT);
    end
  end

`ifdef PLL_SEQ_STATUS_EN
  logic [7:0] lock_loss_r;

  // Lock-loss event counter; survives sw_relock, cleared only by rst_n.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_r <= 8'd0;
    end else if (!sw_relock && (state_r == ST_RUN) && !lk_s && (lock_loss_r != 8'd255)) begin
      lock_loss_r <= lock_loss_r + 8'd1;
    end else begin
      lock_loss_r <= lock_loss_r;
    end
  end

  assign lock_loss_cnt = lock_loss_r;
`endif

  assign pll_rst     = pll_rst_r;
  assign sys_reset_n = sys_reset_n_r;
  assign pll_ready   = pll_ready_r;
  assign fault       = fault_r;
  assign retry_cnt   = retry_r;
  assign state       = state_r;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: cycle model plus directed literal checks.
module tb_pll_lock_sequencer;

  localparam int RP = 4;
  localparam int SC = 8;
  localparam int TO = 50;
  localparam int MR = 2;
  localparam int SY = 2;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_relock;
  logic       pll_rst, sys_reset_n, pll_ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;
`ifdef PLL_SEQ_STATUS_EN
  logic [7:0] lock_loss_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_STABLE_CYCLES (SC),
    .LOCK_TIMEOUT_CYCLES(TO),
    .MAX_RETRIES        (MR),
    .SYNC_STAGES        (SY)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .sw_relock   (sw_relock),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .pll_ready   (pll_ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .state       (state)
`ifdef PLL_SEQ_STATUS_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
  endtask

  task automatic wait_state(input int s, input int maxc, input string name);
    int i;
    i = 0;
    while (int'(state) != s && i < maxc) begin
      @(negedge refclk);
      i++;
    end
    chk(name, int'(state), s);
  endtask

  // ---- behavioural model: phase, attempt age, locked run length, retries ----
  int m_st, m_rc, m_age, m_run, m_hold, m_llc;
  int n_st, n_rc, n_age, n_run, n_hold, n_llc;
  logic [SY-1:0] m_hist;
  logic m_lk;
  assign m_lk = m_hist[SY-1];

  always_comb begin
    n_st = m_st; n_rc = m_rc; n_age = m_age; n_run = m_run; n_hold = m_hold; n_llc = m_llc;
    if (sw_relock) begin
      n_st = 0; n_rc = 0; n_age = 0; n_run = 0; n_hold = 0;
    end else if (m_st == 0) begin
      n_hold = m_hold + 1;
      if (n_hold == RP) begin n_st = 1; n_age = 0; n_hold = 0; end
    end else if (m_st == 1 || m_st == 2) begin
      n_age = m_age + 1;
      n_run = (m_st == 2 && m_lk) ? m_run + 1 : m_run;
      if (m_st == 2 && m_lk && n_run == SC) begin
        n_st = 3; n_rc = 0;
      end else if (n_age == TO) begin
        n_hold = 0;
        if (m_rc == MR - 1) begin n_st = 4; n_rc = MR; end
        else begin n_st = 0; n_rc = m_rc + 1; end
      end else if (m_st == 1 && m_lk) begin
        n_st = 2; n_run = 0;
      end else if (m_st == 2 && !m_lk) begin
        n_st = 1;
      end
    end else if (m_st == 3) begin
      if (!m_lk) begin
        n_st = 0; n_hold = 0;
        if (m_llc < 255) n_llc = m_llc + 1;
      end
    end
  end

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0; m_rc <= 0; m_age <= 0; m_run <= 0; m_hold <= 0; m_llc <= 0; m_hist <= '0;
    end else begin
      m_st <= n_st; m_rc <= n_rc; m_age <= n_age; m_run <= n_run; m_hold <= n_hold; m_llc <= n_llc;
      m_hist <= {m_hist[SY-2:0], pll_locked};
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge refclk) begin
    if (chk_en) begin
      chk("m_state", int'(state), m_st);
      chk("m_retry_cnt", int'(retry_cnt), m_rc);
      chk("m_pll_rst", int'(pll_rst), (m_st == 0 || m_st == 4) ? 1 : 0);
      chk("m_sys_reset_n", int'(sys_reset_n), (m_st == 3) ? 1 : 0);
      chk("m_pll_ready", int'(pll_ready), (m_st == 3) ? 1 : 0);
      chk("m_fault", int'(fault), (m_st == 4) ? 1 : 0);
`ifdef PLL_SEQ_STATUS_EN
      chk("m_lock_loss_cnt", int'(lock_loss_cnt), m_llc);
`endif
    end
  end

  // ---- directed stimulus with hand-computed expectations ----
  initial begin
    int rst_hi, rise, st2, runat, lo, wl;
    rst_n = 1'b0; pll_locked = 1'b1; sw_relock = 1'b0;
    repeat (3) @(negedge refclk);
    chk_en = 1'b1;
    chk("rst_state", int'(state), 0);
    chk("rst_pll_rst", int'(pll_rst), 1);
    chk("rst_sys_reset_n", int'(sys_reset_n), 0);
    chk("rst_retry", int'(retry_cnt), 0);

    // bring-up with lock present from the start
    rst_n = 1'b1;
    rst_hi = pll_rst ? 1 : 0;
    rise = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge refclk);
      if (pll_rst) rst_hi++;
      if (sys_reset_n && rise == 0) rise = i;
    end
    chk("bringup_pll_rst_len", rst_hi, 4);
    chk_rng("bringup_rise_cycle", rise, 13, 15);
    chk("bringup_state", int'(state), 3);
    chk("bringup_ready", int'(pll_ready), 1);

    // sw_relock from RUN
    sw_relock = 1'b1;
    @(negedge refclk);
    sw_relock = 1'b0;
    chk("relock_run_state", int'(state), 0);
    chk("relock_run_fault", int'(fault), 0);
    chk("relock_run_retry", int'(retry_cnt), 0);
    chk("relock_run_ready", int'(pll_ready), 0);

    // one-cycle lock glitch seen by the FSM at stable count 5
    wait_state(2, 20, "glitch_reach_stable");
    repeat (3) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    st2 = -1; runat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge refclk);
      if (i == 2) st2 = int'(state);
      if (state == 3'd3 && runat == 0) runat = i;
    end
    chk("glitch_back_to_wait", st2, 1);
    chk("glitch_run_cycle", runat, 11);

    // lock loss while in RUN
    pll_locked = 1'b0;
    lo = 0; rst_hi = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge refclk);
      if (i == 3) pll_locked = 1'b1;
      if (!sys_reset_n && lo == 0) lo = i;
      if (pll_rst) rst_hi++;
    end
    chk("lockloss_delay", lo, 3);
    chk("lockloss_pll_rst_len", rst_hi, 4);
    wait_state(3, 5, "lockloss_relock_run");
`ifdef PLL_SEQ_STATUS_EN
    chk("lockloss_count", int'(lock_loss_cnt), 1);
`endif

    // lock lost for good: two timeouts then FAULT
    pll_locked = 1'b0;
    wl = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge refclk);
      if (state == 3'd1 && retry_cnt == 2'd0) wl++;
      if (state == 3'd4) break;
    end
    chk("timeout_wait_cycles", wl, 50);
    chk("fault_state", int'(state), 4);
    chk("fault_flag", int'(fault), 1);
    chk("fault_pll_rst", int'(pll_rst), 1);
    chk("fault_retry", int'(retry_cnt), 2);
    chk("fault_sys_reset_n", int'(sys_reset_n), 0);

    // sw_relock from FAULT
    sw_relock = 1'b1;
    @(negedge refclk);
    sw_relock = 1'b0;
    chk("relock_fault_state", int'(state), 0);
    chk("relock_fault_flag", int'(fault), 0);
    chk("relock_fault_retry", int'(retry_cnt), 0);
    chk("relock_fault_pll_rst", int'(pll_rst), 1);

    // asynchronous reset in the middle of STABLE
    pll_locked = 1'b1;
    wait_state(2, 20, "async_reach_stable");
    @(negedge refclk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_pll_rst", int'(pll_rst), 1);
    chk("async_sys_reset_n", int'(sys_reset_n), 0);
    chk("async_ready", int'(pll_ready), 0);
    chk("async_fault", int'(fault), 0);
    chk("async_retry", int'(retry_cnt), 0);
`ifdef PLL_SEQ_STATUS_EN
    chk("async_lock_loss_cnt", int'(lock_loss_cnt), 0);
`endif
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
    repeat (5) @(negedge refclk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
